// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants and
// small bit helpers used by the receiver (and its transmitter peer).
package uart_pkg;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t RX_IDLE   = 3'd0;
   localparam rx_state_t RX_START  = 3'd1;
   localparam rx_state_t RX_DATA   = 3'd2;
   localparam rx_state_t RX_PARITY = 3'd3;
   localparam rx_state_t RX_STOP   = 3'd4;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // acc is the XOR of the eight data bits; p is the received parity bit.
   function automatic logic parity_err(input logic [1:0] mode, input logic acc, input logic p);
      logic err;
      if (mode == PARITY_ODD) begin
         err = ~(acc ^ p);
      end else begin
         err = acc ^ p;
      end
      return err;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame configuration in, byte and
// status out. The receiver uses the slave modport, the line/host side the master.
interface uart_rx_if;
   logic       rx_in;
   logic [1:0] parity_mode;
   logic [1:0] stop_bit;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_busy;

   modport master (
      output rx_in, parity_mode, stop_bit,
      input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
   );

   modport slave (
      input  rx_in, parity_mode, stop_bit,
      output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect.
// With UART_RX_MAJORITY_EN the first-stage value is exported as a one-cycle look-ahead.
module uart_rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic rx_s_o,
   output logic rx_fall_o
`ifdef UART_RX_MAJORITY_EN
   ,
   output logic rx_ahead_o
`endif
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Line idles high, so every stage resets to 1 to avoid a false edge after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_s_o    = sync_q;
   assign rx_fall_o = prev_q & ~sync_q;

`ifdef UART_RX_MAJORITY_EN
   assign rx_ahead_o = meta_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8 data bits, none/even/odd parity, 1-4 stop bits).
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote at each sample point.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic     clk_uart,
   input  logic     rst,
   uart_rx_if.slave rx_if
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] TICK_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] TICK_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

   logic rx_s;
   logic rx_fall;
   logic sample_s;
   logic has_par_s;
   logic [CNT_W-1:0] tick_next_s;
   logic ferr_next_s;

   rx_state_t state_q, state_d;
   logic [CNT_W-1:0] tick_q, tick_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic par_acc_q, par_acc_d;
   logic perr_q, perr_d;
   logic ferr_q, ferr_d;
   logic [1:0] mode_q, mode_d;
   logic [1:0] stop_q, stop_d;
   logic [7:0] data_q, data_d;
   logic valid_q, valid_d;
   logic perr_out_q, perr_out_d;
   logic ferr_out_q, ferr_out_d;
   logic busy_q, busy_d;

`ifdef UART_RX_MAJORITY_EN
   logic rx_ahead_s;
   logic hist_q;
`endif

   uart_rx_sync u_sync (
      .clk_i     (clk_uart),
      .rst_i     (rst),
      .rx_i      (rx_if.rx_in),
      .rx_s_o    (rx_s),
      .rx_fall_o (rx_fall)
`ifdef UART_RX_MAJORITY_EN
      ,
      .rx_ahead_o(rx_ahead_s)
`endif
   );

`ifdef UART_RX_MAJORITY_EN
   // Previous synchronised sample; with the look-ahead this centres the vote on the sample tick.
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= rx_s;
      end
   end

   assign sample_s = maj3(hist_q, rx_s, rx_ahead_s);
`else
   assign sample_s = rx_s;
`endif

   assign has_par_s   = (mode_q == PARITY_EVEN) || (mode_q == PARITY_ODD);
   assign tick_next_s = (tick_q == TICK_LAST) ? TICK_ZERO : (tick_q + TICK_ONE);
   assign ferr_next_s = ferr_q | ~sample_s;

   // Frame FSM: next-state, counters, shift register and output loads.
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_acc_d  = par_acc_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      mode_d     = mode_q;
      stop_d     = stop_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      busy_d     = busy_q;

      case (state_q)
         RX_IDLE: begin
            tick_d    = TICK_ZERO;
            bit_cnt_d = 3'd0;
            if (rx_fall) begin
               state_d   = RX_START;
               busy_d    = 1'b1;
               mode_d    = rx_if.parity_mode;
               stop_d    = rx_if.stop_bit;
               par_acc_d = 1'b0;
               perr_d    = 1'b0;
               ferr_d    = 1'b0;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (tick_q == TICK_MID) begin
               tick_d = TICK_ZERO;
               if (!sample_s) begin
                  state_d = RX_DATA;
               end else begin
                  state_d = RX_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end
         RX_DATA: begin
            tick_d = tick_next_s;
            if (tick_q == TICK_LAST) begin
               shift_d[bit_cnt_q] = sample_s;
               par_acc_d          = par_acc_q ^ sample_s;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  state_d   = has_par_s ? RX_PARITY : RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               state_d = RX_DATA;
            end
         end
         RX_PARITY: begin
            tick_d = tick_next_s;
            if (tick_q == TICK_LAST) begin
               perr_d    = parity_err(mode_q, par_acc_q, sample_s);
               bit_cnt_d = 3'd0;
               state_d   = RX_STOP;
            end else begin
               state_d = RX_PARITY;
            end
         end
         RX_STOP: begin
            tick_d = tick_next_s;
            if (tick_q == TICK_LAST) begin
               ferr_d = ferr_next_s;
               // Leave at mid last stop bit so a back-to-back start edge is still caught.
               if (bit_cnt_q == {1'b0, stop_q}) begin
                  state_d    = RX_IDLE;
                  bit_cnt_d  = 3'd0;
                  valid_d    = 1'b1;
                  data_d     = shift_q;
                  perr_out_d = perr_q;
                  ferr_out_d = ferr_next_s;
                  busy_d     = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               state_d = RX_STOP;
            end
         end
         default: begin
            state_d = RX_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_uart) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         tick_q     <= TICK_ZERO;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         mode_q     <= PARITY_NONE;
         stop_q     <= 2'd0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_acc_q  <= par_acc_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         mode_q     <= mode_d;
         stop_q     <= stop_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_if.rx_data       = data_q;
   assign rx_if.rx_valid      = valid_q;
   assign rx_if.rx_parity_err = perr_out_q;
   assign rx_if.rx_frame_err  = ferr_out_q;
   assign rx_if.rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16; glitch rejection is exercised
// only when built with UART_RX_MAJORITY_EN.
module tb_uart_rx;

   logic clk_uart = 1'b0;
   logic rst      = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.OVERSAMPLE(16)) dut (
      .clk_uart(clk_uart),
      .rst     (rst),
      .rx_if   (bus)
   );

   always #5 clk_uart = ~clk_uart;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int vcnt   = 0;
   int start_cyc = 0;
   int vcyc   [0:63];
   logic [7:0] h_data [0:63];
   logic       h_perr [0:63];
   logic       h_ferr [0:63];
   logic       h_busy [0:63];

   always @(posedge clk_uart) cyc <= cyc + 1;

   // Strobe monitor: records every rx_valid pulse with its payload.
   always @(negedge clk_uart) begin
      if (bus.rx_valid === 1'b1) begin
         vcyc[vcnt[5:0]]   <= cyc;
         h_data[vcnt[5:0]] <= bus.rx_data;
         h_perr[vcnt[5:0]] <= bus.rx_parity_err;
         h_ferr[vcnt[5:0]] <= bus.rx_frame_err;
         h_busy[vcnt[5:0]] <= bus.rx_busy;
         vcnt              <= vcnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input bit glitch);
      bus.rx_in = v;
      repeat (8) @(negedge clk_uart);
      if (glitch) bus.rx_in = ~v;
      @(negedge clk_uart);
      bus.rx_in = v;
      repeat (7) @(negedge clk_uart);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_par, input logic p,
                             input int nstop, input logic [3:0] stop_vals,
                             input int glitch_bit, input bit tweak);
      start_cyc = cyc;
      drive_bit(1'b0, 1'b0);
      if (tweak) begin
         bus.parity_mode = 2'd0;
         bus.stop_bit    = 2'd3;
      end
      for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
      if (has_par) drive_bit(p, 1'b0);
      for (int i = 0; i < nstop; i++) drive_bit(stop_vals[i], 1'b0);
      bus.rx_in = 1'b1;
   endtask

   initial begin
      int v0;
      int bcnt;
      bus.rx_in       = 1'b1;
      bus.parity_mode = 2'd0;
      bus.stop_bit    = 2'd0;
      rst             = 1'b1;
      repeat (3) @(negedge clk_uart);
      chk("rst_data",  32'(bus.rx_data), 32'h0);
      chk("rst_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_perr",  32'(bus.rx_parity_err), 32'h0);
      chk("rst_ferr",  32'(bus.rx_frame_err), 32'h0);
      chk("rst_busy",  32'(bus.rx_busy), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk_uart);

      // 1: 0xA5, no parity, one stop bit
      v0 = vcnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("t1_count", 32'(vcnt - v0), 32'd1);
      chk("t1_data", 32'(h_data[v0]), 32'hA5);
      chk("t1_perr", 32'(h_perr[v0]), 32'h0);
      chk("t1_ferr", 32'(h_ferr[v0]), 32'h0);
      chk("t1_busy_at_strobe", 32'(h_busy[v0]), 32'h0);
      chk("t1_latency", 32'(vcyc[v0] - start_cyc), 32'd155);

      // parity_mode 3 behaves as no parity
      bus.parity_mode = 2'd3;
      v0 = vcnt;
      send_frame(8'hC3, 1'b0, 1'b0, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("mode3_count", 32'(vcnt - v0), 32'd1);
      chk("mode3_data", 32'(h_data[v0]), 32'hC3);
      chk("mode3_perr", 32'(h_perr[v0]), 32'h0);

      // 2: 0x07 even parity, good then bad parity bit
      bus.parity_mode = 2'd1;
      v0 = vcnt;
      send_frame(8'h07, 1'b1, 1'b1, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("t2a_data", 32'(h_data[v0]), 32'h07);
      chk("t2a_perr", 32'(h_perr[v0]), 32'h0);
      v0 = vcnt;
      send_frame(8'h07, 1'b1, 1'b0, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("t2b_count", 32'(vcnt - v0), 32'd1);
      chk("t2b_data", 32'(h_data[v0]), 32'h07);
      chk("t2b_perr", 32'(h_perr[v0]), 32'h1);

      // config changed mid-frame must be ignored
      v0 = vcnt;
      send_frame(8'h07, 1'b1, 1'b0, 1, 4'b1111, -1, 1'b1);
      repeat (4) @(negedge clk_uart);
      chk("latch_count", 32'(vcnt - v0), 32'd1);
      chk("latch_perr", 32'(h_perr[v0]), 32'h1);
      chk("latch_latency", 32'(vcyc[v0] - start_cyc), 32'd171);

      // odd parity, four stop bits
      bus.parity_mode = 2'd2;
      bus.stop_bit    = 2'd3;
      v0 = vcnt;
      send_frame(8'h81, 1'b1, 1'b1, 4, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("stop4_data", 32'(h_data[v0]), 32'h81);
      chk("stop4_perr", 32'(h_perr[v0]), 32'h0);
      chk("stop4_ferr", 32'(h_ferr[v0]), 32'h0);
      chk("stop4_latency", 32'(vcyc[v0] - start_cyc), 32'd219);

      // 3: false start, line low for 4 cycles
      bus.parity_mode = 2'd0;
      bus.stop_bit    = 2'd0;
      v0   = vcnt;
      bcnt = 0;
      bus.rx_in = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk_uart);
         if (bus.rx_busy === 1'b1) bcnt++;
         if (i == 4) bus.rx_in = 1'b1;
      end
      chk("t3_busy_cycles", 32'(bcnt), 32'd8);
      chk("t3_busy_end", 32'(bus.rx_busy), 32'h0);
      chk("t3_no_strobe", 32'(vcnt - v0), 32'd0);

      // 4: 0x3C, two stop bits, second one low
      bus.stop_bit = 2'd1;
      v0 = vcnt;
      send_frame(8'h3C, 1'b0, 1'b0, 2, 4'b0001, -1, 1'b0);
      repeat (10) @(negedge clk_uart);
      chk("t4_count", 32'(vcnt - v0), 32'd1);
      chk("t4_data", 32'(h_data[v0]), 32'h3C);
      chk("t4_ferr", 32'(h_ferr[v0]), 32'h1);
      chk("t4_perr", 32'(h_perr[v0]), 32'h0);

      // 5: reset pulse during data bit 4 of 0xF0
      bus.stop_bit = 2'd0;
      v0 = vcnt;
      for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b0);
      bus.rx_in = 1'b1;
      repeat (8) @(negedge clk_uart);
      chk("t5_busy_before", 32'(bus.rx_busy), 32'h1);
      rst = 1'b1;
      @(negedge clk_uart);
      chk("t5_data", 32'(bus.rx_data), 32'h0);
      chk("t5_ferr", 32'(bus.rx_frame_err), 32'h0);
      chk("t5_busy", 32'(bus.rx_busy), 32'h0);
      chk("t5_valid", 32'(bus.rx_valid), 32'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk_uart);
      chk("t5_no_strobe", 32'(vcnt - v0), 32'd0);
      send_frame(8'h5A, 1'b0, 1'b0, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("t5_next_count", 32'(vcnt - v0), 32'd1);
      chk("t5_next_data", 32'(h_data[v0]), 32'h5A);
      chk("t5_next_ferr", 32'(h_ferr[v0]), 32'h0);

      // 6: back-to-back 0x00 then 0xFF, odd parity, no idle gap
      bus.parity_mode = 2'd2;
      v0 = vcnt;
      send_frame(8'h00, 1'b1, 1'b1, 1, 4'b1111, -1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 1, 4'b1111, -1, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("t6_count", 32'(vcnt - v0), 32'd2);
      chk("t6_data0", 32'(h_data[v0]), 32'h00);
      chk("t6_data1", 32'(h_data[v0 + 1]), 32'hFF);
      chk("t6_errs0", 32'({h_perr[v0], h_ferr[v0]}), 32'h0);
      chk("t6_errs1", 32'({h_perr[v0 + 1], h_ferr[v0 + 1]}), 32'h0);

`ifdef UART_RX_MAJORITY_EN
      // single-cycle glitch at the sample point of data bit 3
      bus.parity_mode = 2'd0;
      v0 = vcnt;
      send_frame(8'h55, 1'b0, 1'b0, 1, 4'b1111, 3, 1'b0);
      repeat (4) @(negedge clk_uart);
      chk("glitch_count", 32'(vcnt - v0), 32'd1);
      chk("glitch_data", 32'(h_data[v0]), 32'h55);
      chk("glitch_latency", 32'(vcyc[v0] - start_cyc), 32'd155);
`endif

      repeat (10) @(negedge clk_uart);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
